// File: rtl/adder_exhaustive_checker_if.sv
// Operand/result and control bundle between the exhaustive adder checker, its adder and its controller.
// FIRST_FAIL_CAPTURE_EN adds the first-failure diagnostic signals.
interface adder_exhaustive_checker_if #(parameter int WIDTH = 5);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   dut_a;
  logic [WIDTH-1:0]   dut_b;
  logic [WIDTH-1:0]   dut_sum;
  logic               dut_cout;
  logic               busy;
  logic               done;
  logic               pass;
  logic [2*WIDTH:0]   err_cnt;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic               first_fail_valid;
  logic [WIDTH-1:0]   first_fail_a;
  logic [WIDTH-1:0]   first_fail_b;
  logic [WIDTH:0]     first_fail_got;
`endif

  modport master (
    input  start, abort, dut_sum, dut_cout,
    output dut_a, dut_b, busy, done, pass, err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    , output first_fail_valid, first_fail_a, first_fail_b, first_fail_got
`endif
  );

  modport slave (
    output start, abort, dut_sum, dut_cout,
    input  dut_a, dut_b, busy, done, pass, err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    , input first_fail_valid, first_fail_a, first_fail_b, first_fail_got
`endif
  );
endinterface

// File: rtl/adder_exhaustive_checker.sv
// Walks every a/b operand pair through a WIDTH-bit adder and counts results that differ from a+b.
// Optional FIRST_FAIL_CAPTURE_EN records the operands and result of the first mismatch in a run.
module adder_exhaustive_checker #(
  parameter int WIDTH = 5,
  parameter int LAT   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  adder_exhaustive_checker_if.master  bus
);
  localparam int CW = 2*WIDTH;
  localparam int EW = 2*WIDTH+1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LAT:0][WIDTH-1:0]   a_pipe_q, a_pipe_d, b_pipe_q, b_pipe_d;
  logic [LAT:0]              vld_pipe_q, vld_pipe_d;
  logic [EW-1:0]             err_cnt_q, err_cnt_d;
  logic                      busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [WIDTH:0]            exp_res, got_res;
  logic                      mismatch;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic                      ff_vld_q, ff_vld_d;
  logic [WIDTH-1:0]          ff_a_q, ff_a_d, ff_b_q, ff_b_d;
  logic [WIDTH:0]            ff_got_q, ff_got_d;
`endif

  // Stage 0 of the delay line is the operand pair currently on dut_a/dut_b.
  assign exp_res  = {1'b0, a_pipe_q[LAT]} + {1'b0, b_pipe_q[LAT]};
  assign got_res  = {bus.dut_cout, bus.dut_sum};
  assign mismatch = vld_pipe_q[LAT] && (got_res != exp_res);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    a_pipe_d   = a_pipe_q << WIDTH;
    b_pipe_d   = b_pipe_q << WIDTH;
    vld_pipe_d = vld_pipe_q << 1;
`ifdef FIRST_FAIL_CAPTURE_EN
    ff_vld_d   = ff_vld_q;
    ff_a_d     = ff_a_q;
    ff_b_d     = ff_b_q;
    ff_got_d   = ff_got_q;
`endif

    if (mismatch) begin
      err_cnt_d = err_cnt_q + 1'b1;
`ifdef FIRST_FAIL_CAPTURE_EN
      if (!ff_vld_q) begin
        ff_vld_d = 1'b1;
        ff_a_d   = a_pipe_q[LAT];
        ff_b_d   = b_pipe_q[LAT];
        ff_got_d = got_res;
      end
`endif
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d       = RUN;
          cnt_d         = '0;
          vld_pipe_d[0] = 1'b1;
          err_cnt_d     = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
          ff_vld_d      = 1'b0;
          ff_a_d        = '0;
          ff_b_d        = '0;
          ff_got_d      = '0;
`endif
        end
      end
      RUN: begin
        if (cnt_q == '1) begin
          cnt_d = '0;
          if (LAT > 0) begin
            state_d = DRAIN;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end
        end else begin
          cnt_d         = cnt_q + 1'b1;
          a_pipe_d[0]   = cnt_d[CW-1:WIDTH];
          b_pipe_d[0]   = cnt_d[WIDTH-1:0];
          vld_pipe_d[0] = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(LAT-1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Abort overrides everything, including a compare landing on the same edge.
    if (bus.abort) begin
      state_d    = IDLE;
      cnt_d      = '0;
      err_cnt_d  = err_cnt_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      a_pipe_d   = '0;
      b_pipe_d   = '0;
      vld_pipe_d = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_vld_d   = 1'b0;
      ff_a_d     = '0;
      ff_b_d     = '0;
      ff_got_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_pipe_q   <= '0;
      b_pipe_q   <= '0;
      vld_pipe_q <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_vld_q   <= 1'b0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_got_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_pipe_q   <= a_pipe_d;
      b_pipe_q   <= b_pipe_d;
      vld_pipe_q <= vld_pipe_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_vld_q   <= ff_vld_d;
      ff_a_q     <= ff_a_d;
      ff_b_q     <= ff_b_d;
      ff_got_q   <= ff_got_d;
`endif
    end
  end

  assign bus.dut_a   = a_pipe_q[0];
  assign bus.dut_b   = b_pipe_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_cnt_q;
`ifdef FIRST_FAIL_CAPTURE_EN
  assign bus.first_fail_valid = ff_vld_q;
  assign bus.first_fail_a     = ff_a_q;
  assign bus.first_fail_b     = ff_b_q;
  assign bus.first_fail_got   = ff_got_q;
`endif
endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Bench: a LAT=0 checker around a fault-injectable combinational adder and a LAT=2 checker
// around a 1- or 2-stage registered adder, both driven by the same start/abort.
module tb_adder_exhaustive_checker;
  localparam int W = 5;
  localparam int N = 1 << (2*W);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_r = 1'b0;
  logic abort_r = 1'b0;
  always #5 clk = ~clk;

  adder_exhaustive_checker_if #(.WIDTH(W)) if0 ();
  adder_exhaustive_checker_if #(.WIDTH(W)) if2 ();
  assign if0.start = start_r;
  assign if0.abort = abort_r;
  assign if2.start = start_r;
  assign if2.abort = abort_r;

  adder_exhaustive_checker #(.WIDTH(W), .LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  adder_exhaustive_checker #(.WIDTH(W), .LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Adder under test for u0: 0 correct, 1 sum[0] stuck 0, 2 cout flipped at (fa,fb), 3 sum[1] flipped on a mask
  int fault0 = 0;
  logic [W-1:0] fa = '0, fb = '0, fmask = 5'd1;
  function automatic logic [W:0] adder0(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (fault0)
      1: s[0] = 1'b0;
      2: if (a == fa && b == fb) s[W] = ~s[W];
      3: if (((a ^ b) & fmask) == fmask) s[1] = ~s[1];
      default: ;
    endcase
    return s;
  endfunction
  logic [W:0] res0;
  always @(if0.dut_a or if0.dut_b or fault0 or fa or fb or fmask) res0 = adder0(if0.dut_a, if0.dut_b);
  assign {if0.dut_cout, if0.dut_sum} = res0;

  int stages2 = 2;
  logic [W:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= {1'b0, if2.dut_a} + {1'b0, if2.dut_b};
    s2 <= s1;
  end
  assign {if2.dut_cout, if2.dut_sum} = (stages2 == 2) ? s2 : s1;

  // Reference: count vectors among the first nvec whose adder output differs from integer a+b
  function automatic int exp_errs(input int nvec);
    int e = 0;
    for (int i = 0; i < nvec; i++) begin
      int a = i / (1 << W);
      int b = i % (1 << W);
      if (int'(adder0(W'(a), W'(b))) != a + b) e++;
    end
    return e;
  endfunction

  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int d0, d2;
  bit seq_ok, busy_ok;
  task automatic run(input int abort_at, input bit extra);
    d0 = -1; d2 = -1; seq_ok = 1'b1; busy_ok = 1'b1;
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    if (if0.dut_a !== '0 || if0.dut_b !== '0) seq_ok = 1'b0;
    if (if0.busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      start_r = extra && (k < 1000) && ($urandom_range(0, 3) == 0);
      abort_r = (k == abort_at);
      tick();
      if (k == abort_at) break;
      if (k < N) begin
        if (if0.dut_a !== W'(k >> W) || if0.dut_b !== W'(k)) seq_ok = 1'b0;
        if (if0.busy !== 1'b1) busy_ok = 1'b0;
      end
      if (d0 < 0 && if0.done === 1'b1) d0 = k;
      if (d2 < 0 && if2.done === 1'b1) d2 = k;
      if (d0 >= 0 && d2 >= 0) break;
    end
    start_r = 1'b0;
    abort_r = 1'b0;
  endtask

  int e_exp, e_abort, held;

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_pass", if0.pass, 0);
    chk("rst_err", if0.err_cnt, 0);
    chk("rst_a", if0.dut_a, 0);
    chk("rst_b2", if2.dut_b, 0);
    rst_n = 1'b1;
    tick();

    // correct adders: LAT=0 done at 1024, LAT=2 done at 1026
    fault0 = 0; stages2 = 2;
    run(-1, 1'b0);
    chk("t1_done_edge", d0, N);
    chk("t1_seq", seq_ok, 1);
    chk("t1_busy_run", busy_ok, 1);
    chk("t1_busy_end", if0.busy, 0);
    chk("t1_err", if0.err_cnt, 0);
    chk("t1_pass", if0.pass, 1);
    chk("t1_a_idle", if0.dut_a, 0);
    chk("t4_done_edge", d2, N + 2);
    chk("t4_err", if2.err_cnt, 0);
    chk("t4_pass", if2.pass, 1);

    // sum[0] stuck at 0
    fault0 = 1;
    run(-1, 1'b0);
    chk("t2_done_edge", d0, N);
    chk("t2_err", if0.err_cnt, 512);
    chk("t2_pass", if0.pass, 0);

    // cout flipped for a=31,b=31
    fault0 = 2; fa = 5'd31; fb = 5'd31;
    run(-1, 1'b0);
    chk("t3_err", if0.err_cnt, 1);
    chk("t3_pass", if0.pass, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("t3_ff_valid", if0.first_fail_valid, 1);
    chk("t3_ff_a", if0.first_fail_a, 31);
    chk("t3_ff_b", if0.first_fail_b, 31);
    chk("t3_ff_got", if0.first_fail_got, 30);
`endif

    // cout flipped at a random pair
    fa = W'($urandom_range(0, 31)); fb = W'($urandom_range(0, 31));
    run(-1, 1'b0);
    chk("t3r_err", if0.err_cnt, 1);
    chk("t3r_done_edge", d0, N);

    // random-mask fault, model-predicted count
    fault0 = 3; fmask = W'($urandom_range(1, 31));
    e_exp = exp_errs(N);
    run(-1, 1'b0);
    chk("tm_err", if0.err_cnt, e_exp);
    chk("tm_pass", if0.pass, (e_exp == 0) ? 1 : 0);

    // LAT=2 checker around a 1-stage adder
    fault0 = 0; stages2 = 1;
    run(-1, 1'b0);
    chk("t4b_err_nz", (if2.err_cnt != 0) ? 1 : 0, 1);
    chk("t4b_pass", if2.pass, 0);
    stages2 = 2;

    // abort at a random edge, partial count held, then a clean rerun
    fault0 = 1;
    e_abort = $urandom_range(50, 900);
    e_exp = exp_errs(e_abort - 1);
    run(e_abort, 1'b0);
    chk("t5_busy", if0.busy, 0);
    chk("t5_done", if0.done, 0);
    chk("t5_err_held", if0.err_cnt, e_exp);
    held = int'(if0.err_cnt);
    tick();
    chk("t5_err_hold2", if0.err_cnt, e_exp);
    chk("t5_a_idle", if0.dut_a, 0);
    fault0 = 0;
    run(-1, 1'b0);
    chk("t5_rerun_err", if0.err_cnt, 0);
    chk("t5_rerun_pass", if0.pass, 1);
    chk("t5_rerun_edge", d0, N);

    // stray start pulses during RUN
    fault0 = 3; fmask = W'($urandom_range(1, 31));
    e_exp = exp_errs(N);
    run(-1, 1'b1);
    chk("t6_seq", seq_ok, 1);
    chk("t6_done_edge", d0, N);
    chk("t6_err", if0.err_cnt, e_exp);

    // reset in the middle of a run
    fault0 = 1;
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    repeat (499) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_busy", if0.busy, 0);
    chk("t6r_err", if0.err_cnt, 0);
    chk("t6r_a", if0.dut_a, 0);
    chk("t6r_b", if0.dut_b, 0);
    chk("t6r_done", if0.done, 0);
    rst_n = 1'b1;
    tick();
    run(-1, 1'b0);
    chk("t6r_rerun_edge", d0, N);
    chk("t6r_rerun_err", if0.err_cnt, 512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
